// File: rtl/sprite_arb_pkg.sv
// sprite_arb_pkg
// Shared definitions for the sprite ROM arbiter slice.
//   NUM_REQ_DEF : default number of pixel requesters
//   ID_W        : width of a requester id for the default configuration
//   req_id_t    : requester id type
//   REQ_*       : fixed requester indices in the video path
package sprite_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W        = $clog2(NUM_REQ_DEF);

  typedef logic [ID_W-1:0] req_id_t;

  // Index 0 is the background path and always has fixed priority.
  localparam req_id_t REQ_BG   = req_id_t'(0);
  localparam req_id_t REQ_PADL = req_id_t'(1);
  localparam req_id_t REQ_PADR = req_id_t'(2);
  localparam req_id_t REQ_BALL = req_id_t'(3);

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin one-hot picker. Searches the request vector
// starting at index ptr, wrapping at N back to 0, and grants the first
// set bit found.
//   req : request vector (N bits)
//   ptr : search start index ($clog2(N) bits), must be < N
//   gnt : one-hot grant, zero when req is zero
module rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [PW:0] idx;
  logic        found;

  // Walk N positions from ptr; the wrap is an explicit compare/subtract so
  // non-power-of-two N works without a modulo.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) begin
        idx = idx - (PW+1)'(N);
      end
      if (!found && req[idx[PW-1:0]]) begin
        gnt[idx[PW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
// Shares the single synchronous sprite ROM read port between the
// background, paddle and ball pixel requesters. One request is granted per
// cycle; the winner's address is registered to the ROM and the returned
// palette index is registered one cycle later, tagged with the requester id.
//
// Ports:
//   vga_clk     : pixel clock, rising-edge state updates
//   reset_n     : asynchronous active-low reset
//   req         : per-requester request
//   req_addr    : flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt         : combinational one-hot grant
//   rom_address : registered ROM address (ROM samples on falling edge)
//   rom_q       : ROM data, valid before the next rising edge
//   rsp_valid   : response valid
//   rsp_id      : requester the response belongs to
//   rsp_data    : ROM data for that requester
//
// Optional build macro SPRITE_ARB_STARVE_GUARD_EN adds per-requester wait
// counters so that requesters 1..NUM_REQ-1 cannot be starved forever by the
// background path.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 3,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                       vga_clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [ADDR_W-1:0]          rom_address,
  input  logic [DATA_W-1:0]          rom_q,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]          rsp_data
);

  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("sprite_rom_arbiter: NUM_REQ must be in 2..8");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("sprite_rom_arbiter: STARVE_LIMIT must be at least 1");
  end

  logic [IDW-1:0]     rr_ptr;
  logic [NUM_REQ-1:0] rr_req;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [IDW-1:0]     win_id;
  logic [ADDR_W-1:0]  win_addr;
  logic               xfer;
  logic               s1_valid;
  logic [IDW-1:0]     s1_id;

  // The round-robin picker only ever sees requesters 1..NUM_REQ-1; bit 0 is
  // masked so the wrap from the top index lands back on 1.
  assign rr_req = req & ~NUM_REQ'(1);

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req (rr_req),
    .ptr (rr_ptr),
    .gnt (rr_gnt)
  );

`ifdef SPRITE_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]   wait_cnt [1:NUM_REQ-1];
  logic [NUM_REQ-1:0] starved;
  logic [NUM_REQ-1:0] starve_gnt;

  // Count cycles each requester has been left waiting; saturate at the limit
  // and clear once it is served or stops asking.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NUM_REQ; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REQ; i++) begin
        if (!req[i] || gnt[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
          wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Starved requesters beat everyone; the lowest starved index wins, which is
  // the lowest set bit of the starved vector.
  always_comb begin
    starved = '0;
    for (int i = 1; i < NUM_REQ; i++) begin
      starved[i] = req[i] && (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
    end
    starve_gnt = starved & (~starved + NUM_REQ'(1));
  end
`endif

  // Grant: background has fixed priority, otherwise round-robin among the
  // rest. With the starvation guard a starved requester overrides both.
  always_comb begin
    if (req[0]) begin
      gnt = NUM_REQ'(1);
    end else begin
      gnt = rr_gnt;
    end
`ifdef SPRITE_ARB_STARVE_GUARD_EN
    if (|starved) begin
      gnt = starve_gnt;
    end
`endif
  end

  // Encode the one-hot grant into an id and select the winner's address.
  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_id = IDW'(i);
      end
    end
  end

  assign xfer     = |gnt;
  assign win_addr = req_addr[win_id*ADDR_W +: ADDR_W];

  // Round-robin pointer moves just past a served requester 1..NUM_REQ-1;
  // background grants leave it alone.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= IDW'(1);
    end else if (xfer && (win_id != IDW'(0))) begin
      if (win_id == IDW'(NUM_REQ - 1)) begin
        rr_ptr <= IDW'(1);
      end else begin
        rr_ptr <= win_id + IDW'(1);
      end
    end
  end

  // Stage 1: capture the winner. The ROM address only changes on a transfer
  // so the ROM input does not toggle while idle.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid    <= 1'b0;
      s1_id       <= '0;
      rom_address <= '0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_id       <= win_id;
        rom_address <= win_addr;
      end
    end
  end

  // Stage 2: capture ROM data for the stage-1 access; id/data hold when idle.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_id   <= s1_id;
        rsp_data <= rom_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter
// Self-checking bench for sprite_rom_arbiter (default build). A 4-requester
// instance carries the directed and random scenarios; a 3-requester instance
// checks the round-robin wrap on a non-power-of-two width.
module tb_sprite_rom_arbiter;
  import sprite_arb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 19;
  localparam int DW = 3;

  logic             vga_clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    gnt;
  logic [AW-1:0]    rom_address;
  logic [DW-1:0]    rom_q;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [DW-1:0]    rsp_data;

  logic [2:0]       req3;
  logic [3*AW-1:0]  req_addr3;
  logic [2:0]       gnt3;
  logic [AW-1:0]    rom_address3;
  logic [DW-1:0]    rom_q3;
  logic             rsp_valid3;
  logic [1:0]       rsp_id3;
  logic [DW-1:0]    rsp_data3;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } exp_rsp_t;

  sprite_rom_arbiter #(
    .NUM_REQ (NR), .ADDR_W (AW), .DATA_W (DW), .STARVE_LIMIT (15)
  ) dut (
    .vga_clk (vga_clk), .reset_n (reset_n), .req (req), .req_addr (req_addr),
    .gnt (gnt), .rom_address (rom_address), .rom_q (rom_q),
    .rsp_valid (rsp_valid), .rsp_id (rsp_id), .rsp_data (rsp_data)
  );

  sprite_rom_arbiter #(
    .NUM_REQ (3), .ADDR_W (AW), .DATA_W (DW), .STARVE_LIMIT (15)
  ) dut3 (
    .vga_clk (vga_clk), .reset_n (reset_n), .req (req3), .req_addr (req_addr3),
    .gnt (gnt3), .rom_address (rom_address3), .rom_q (rom_q3),
    .rsp_valid (rsp_valid3), .rsp_id (rsp_id3), .rsp_data (rsp_data3)
  );

  // Pixel clock, 10 time units per period.
  always #5 vga_clk = ~vga_clk;

  // Arbitrary but address-dependent ROM contents.
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = a ^ (a >> 3) ^ (a >> 7);
    return t[DW-1:0] + 3'd5;
  endfunction

  // Synchronous ROMs sample their address on the falling edge.
  always @(negedge vga_clk) begin
    rom_q  <= rom_fn(rom_address);
    rom_q3 <= rom_fn(rom_address3);
  end

  // Reference arbitration: background first, else scan 1..NR-1 circularly
  // starting at ptr. Returns -1 when nobody is requesting.
  function automatic int model_winner(input logic [NR-1:0] r, input int ptr);
    int i;
    if (r == '0) return -1;
    if (r[0]) return 0;
    for (int k = 0; k < NR - 1; k++) begin
      i = 1 + ((ptr - 1 + k) % (NR - 1));
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Hold reset for two cycles with all requests idle; release on a falling edge.
  task automatic applyReset();
    reset_n   = 1'b0;
    req       = '0;
    req_addr  = '0;
    req3      = '0;
    req_addr3 = '0;
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR*AW-1:0] a);
    req      = r;
    req_addr = a;
  endtask

  // Let any trailing responses leave the pipe with requests idle.
  task automatic drain();
    req  = '0;
    req3 = '0;
    repeat (3) @(posedge vga_clk);
    #1;
  endtask

  task automatic test_reset();
    applyReset();
    for (int c = 0; c < 5; c++) begin
      req = '0;
      #1;
      checks++;
      if (gnt !== 4'b0000) begin
        fails++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt);
      end
      @(posedge vga_clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        fails++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
      end
      checks++;
      if (rom_address !== '0) begin
        fails++; $display("[TB] FAIL reset_rom_address: got %0d expected 0", rom_address);
      end
      checks++;
      if (rsp_id !== 2'd0 || rsp_data !== 3'd0) begin
        fails++; $display("[TB] FAIL reset_rsp_fields: got id %0d data %0d expected 0/0", rsp_id, rsp_data);
      end
    end
  endtask

  task automatic test_single_bg();
    logic [NR*AW-1:0] a;
    a = '0;
    a[0 +: AW] = AW'(100);
    applyStimulus(4'b0001, a);
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      fails++; $display("[TB] FAIL bg_gnt: got %b expected 0001", gnt);
    end
    @(posedge vga_clk);
    #1;
    checks++;
    if (rom_address !== AW'(100)) begin
      fails++; $display("[TB] FAIL bg_rom_address: got %0d expected 100", rom_address);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL bg_early_valid: got %b expected 0", rsp_valid);
    end
    req = '0;
    @(posedge vga_clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== REQ_BG || rsp_data !== rom_fn(AW'(100))) begin
      fails++; $display("[TB] FAIL bg_rsp: got v%b id%0d d%0d expected v1 id0 d%0d",
                        rsp_valid, rsp_id, rsp_data, rom_fn(AW'(100)));
    end
    @(posedge vga_clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== rom_fn(AW'(100)) || rom_address !== AW'(100)) begin
      fails++; $display("[TB] FAIL bg_hold: got v%b d%0d addr%0d expected v0 d%0d addr100",
                        rsp_valid, rsp_data, rom_address, rom_fn(AW'(100)));
    end
    drain();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0]    exp_g  [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    int               exp_id [6] = '{-1, 1, 2, 3, -1, -1};
    logic [AW-1:0]    addrs  [4] = '{AW'(0), AW'(200), AW'(300), AW'(400)};
    logic [NR*AW-1:0] a;
    a = '0;
    for (int i = 1; i < NR; i++) a[i*AW +: AW] = addrs[i];
    applyStimulus(4'b1110, a);
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (gnt !== exp_g[c]) begin
        fails++; $display("[TB] FAIL rr_gnt_%0d: got %b expected %b", c, gnt, exp_g[c]);
      end
      @(posedge vga_clk);
      #1;
      req = req & ~exp_g[c];
      checks++;
      if (exp_id[c] >= 0) begin
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id[c]) || rsp_data !== rom_fn(addrs[exp_id[c]])) begin
          fails++; $display("[TB] FAIL rr_rsp_%0d: got v%b id%0d d%0d expected v1 id%0d d%0d", c,
                            rsp_valid, rsp_id, rsp_data, exp_id[c], rom_fn(addrs[exp_id[c]]));
        end
      end else if (rsp_valid !== 1'b0) begin
        fails++; $display("[TB] FAIL rr_idle_%0d: got v%b expected v0", c, rsp_valid);
      end
    end
    drain();
  endtask

  task automatic test_bg_priority();
    logic [NR*AW-1:0] a;
    for (int i = 0; i < NR; i++) a[i*AW +: AW] = AW'($urandom);
    applyStimulus(4'b1111, a);
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if (gnt !== 4'b0001) begin
        fails++; $display("[TB] FAIL prio_gnt_%0d: got %b expected 0001", c, gnt);
      end
      @(posedge vga_clk);
      #1;
    end
    req = 4'b1110;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      fails++; $display("[TB] FAIL prio_ptr_kept: got %b expected 0010", gnt);
    end
    @(posedge vga_clk);
    drain();
  endtask

  task automatic test_reset_midflight();
    logic [NR*AW-1:0] a;
    a = '0;
    a[2*AW +: AW] = AW'(555);
    a[1*AW +: AW] = AW'(66);
    applyStimulus(4'b0100, a);
    #1;
    checks++;
    if (gnt !== 4'b0100) begin
      fails++; $display("[TB] FAIL mid_gnt: got %b expected 0100", gnt);
    end
    @(posedge vga_clk);
    #1;
    req = '0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    #1;
    checks++;
    if (rom_address !== '0) begin
      fails++; $display("[TB] FAIL mid_rom_address: got %0d expected 0", rom_address);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge vga_clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        fails++; $display("[TB] FAIL mid_no_rsp_%0d: got v%b expected v0", c, rsp_valid);
      end
    end
    req = 4'b1110;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      fails++; $display("[TB] FAIL mid_ptr_reset: got %b expected 0010", gnt);
    end
    @(posedge vga_clk);
    drain();
  endtask

  task automatic test_wrap3();
    applyReset();
    req_addr3 = '0;
    req_addr3[2*AW +: AW] = AW'(777);
    req_addr3[1*AW +: AW] = AW'(888);
    req3 = 3'b100;
    #1;
    checks++;
    if (gnt3 !== 3'b100) begin
      fails++; $display("[TB] FAIL wrap_first_gnt: got %b expected 100", gnt3);
    end
    @(posedge vga_clk);
    #1;
    checks++;
    if (rom_address3 !== AW'(777)) begin
      fails++; $display("[TB] FAIL wrap_rom_address: got %0d expected 777", rom_address3);
    end
    req3 = 3'b110;
    #1;
    checks++;
    if (gnt3 !== 3'b010) begin
      fails++; $display("[TB] FAIL wrap_ptr_to_1: got %b expected 010", gnt3);
    end
    @(posedge vga_clk);
    #1;
    checks++;
    if (rsp_valid3 !== 1'b1 || rsp_id3 !== 2'd2 || rsp_data3 !== rom_fn(AW'(777))) begin
      fails++; $display("[TB] FAIL wrap_rsp: got v%b id%0d d%0d expected v1 id2 d%0d",
                        rsp_valid3, rsp_id3, rsp_data3, rom_fn(AW'(777)));
    end
    #1;
    checks++;
    if (gnt3 !== 3'b100) begin
      fails++; $display("[TB] FAIL wrap_ptr_to_2: got %b expected 100", gnt3);
    end
    @(posedge vga_clk);
    drain();
  endtask

  task automatic test_random_traffic();
    logic [NR-1:0] pend;
    logic [AW-1:0] paddr [NR];
    logic [NR-1:0] eg;
    logic [AW-1:0] waddr;
    logic [AW-1:0] exp_rom;
    logic [1:0]    last_id;
    logic [DW-1:0] last_data;
    exp_rsp_t      q [$];
    exp_rsp_t      e;
    int            m_ptr;
    int            w;
    int            cyc;
    applyReset();
    m_ptr = 1; exp_rom = '0; last_id = '0; last_data = '0; pend = '0; cyc = 0; waddr = '0;
    for (int i = 0; i < NR; i++) paddr[i] = '0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (pend[i]) begin
          if ($urandom_range(0, 19) == 0) pend[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          pend[i]  = 1'b1;
          paddr[i] = AW'($urandom);
        end
      end
      req = pend;
      for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = paddr[i];
      #1;
      w  = model_winner(pend, m_ptr);
      eg = (w < 0) ? '0 : (NR'(1) << w);
      checks++;
      if (gnt !== eg) begin
        fails++; $display("[TB] FAIL rand_gnt @%0d: got %b expected %b", n, gnt, eg);
      end
      if (w >= 0) waddr = paddr[w];
      @(posedge vga_clk);
      cyc++;
      if (w >= 0) begin
        if (w > 0) m_ptr = 1 + (w % (NR - 1));
        exp_rom = waddr;
        e.due = cyc + 1; e.id = w; e.data = rom_fn(waddr);
        q.push_back(e);
        pend[w] = 1'b0;
      end
      #1;
      checks++;
      if (rom_address !== exp_rom) begin
        fails++; $display("[TB] FAIL rand_rom_address @%0d: got %0h expected %0h", n, rom_address, exp_rom);
      end
      checks++;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(e.id) || rsp_data !== e.data) begin
          fails++; $display("[TB] FAIL rand_rsp @%0d: got v%b id%0d d%0d expected v1 id%0d d%0d",
                            n, rsp_valid, rsp_id, rsp_data, e.id, e.data);
        end
        last_id   = 2'(e.id);
        last_data = e.data;
      end else if (rsp_valid !== 1'b0 || rsp_id !== last_id || rsp_data !== last_data) begin
        fails++; $display("[TB] FAIL rand_idle @%0d: got v%b id%0d d%0d expected v0 id%0d d%0d",
                          n, rsp_valid, rsp_id, rsp_data, last_id, last_data);
      end
    end
    drain();
  endtask

  // Bound the whole run in case something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    req = '0; req_addr = '0; req3 = '0; req_addr3 = '0;
    test_reset();
    test_single_bg();
    test_round_robin();
    test_bg_priority();
    test_reset_midflight();
    test_wrap3();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
